any1_bus_arbiter: RTL and testbench

//  Shares the single 128-bit ANY-1 system bus (vpa/cyc/stb/ack/we/sel/adr/dat) between NREQ

---
 rtl/any1_pkg.sv | 26 ++
 rtl/any1_rr_picker.sv | 31 +++
 rtl/any1_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_any1_bus_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/any1_pkg.sv
// rtl/any1_pkg.sv - shared types for the ANY-1 system bus arbiter
package any1_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACTIVE,
        ARB_ERR,
        ARB_DRAIN
    } arb_state_t;

    localparam int ARB_TMO_DEFAULT = 255;

    // One master's view of the bus; also used by the any1oo core-side ports.
    typedef struct packed {
        logic         vpa;
        logic         cyc;
        logic         stb;
        logic         we;
        logic [15:0]  sel;
        logic [31:0]  adr;
        logic [127:0] dat;
    } any1_bus_t;

    localparam any1_bus_t ANY1_BUS_IDLE = '0;

endpackage

// File: rtl/any1_rr_picker.sv
// rtl/any1_rr_picker.sv - round-robin find-first starting after the last winner
module any1_rr_picker #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    logic [IW-1:0] cand;

    // Walk last+1, last+2, ... with wrap; the first requester seen wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = last_i;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/any1_bus_arbiter.sv
// rtl/any1_bus_arbiter.sv - round-robin owner of the 128-bit ANY-1 bus with stall timeout
module any1_bus_arbiter
    import any1_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int TMO  = ARB_TMO_DEFAULT,
    parameter int TMOW = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       m_vpa_i,
    input  logic [NREQ-1:0]       m_cyc_i,
    input  logic [NREQ-1:0]       m_stb_i,
    input  logic [NREQ-1:0]       m_we_i,
    input  logic [NREQ-1:0][15:0] m_sel_i,
    input  logic [NREQ-1:0][31:0] m_adr_i,
    input  logic [NREQ-1:0][127:0] m_dat_i,
    output logic [NREQ-1:0]       m_ack_o,
    output logic [NREQ-1:0]       m_err_o,
    output logic [127:0]          m_dat_o,
    output logic                  vpa_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [15:0]           sel_o,
    output logic [31:0]           adr_o,
    output logic [127:0]          dat_o,
    input  logic                  ack_i,
    input  logic [127:0]          dat_i,
    output logic [NREQ-1:0]       gnt_o
);

    localparam int IW = $clog2(NREQ);
    localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TMO - 1);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [TMOW-1:0] tmo_q, tmo_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    any1_bus_t mst_bus;
    any1_bus_t slv_bus;

    any1_rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        mst_bus     = ANY1_BUS_IDLE;
        mst_bus.vpa = m_vpa_i[gidx_q];
        mst_bus.cyc = m_cyc_i[gidx_q];
        mst_bus.stb = m_stb_i[gidx_q];
        mst_bus.we  = m_we_i[gidx_q];
        mst_bus.sel = m_sel_i[gidx_q];
        mst_bus.adr = m_adr_i[gidx_q];
        mst_bus.dat = m_dat_i[gidx_q];
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        slv_bus = ANY1_BUS_IDLE;
        m_ack_o = '0;
        m_err_o = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_ACTIVE;
                    gnt_d   = pick_gnt;
                    gidx_d  = pick_idx;
                    last_d  = pick_idx;
                    tmo_d   = '0;
                end
            end
            ARB_ACTIVE: begin
                slv_bus = mst_bus;
                m_ack_o = gnt_q & {NREQ{ack_i & mst_bus.stb}};
                // Dropping cyc always costs one IDLE cycle before the next grant.
                if (!mst_bus.cyc) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    tmo_d   = '0;
                end else if (mst_bus.stb && !ack_i) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = ARB_ERR;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end else begin
                    tmo_d = '0;
                end
            end
            ARB_ERR: begin
                m_err_o = gnt_q;
                state_d = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                // Grant is held until the aborted master lets go of cyc.
                if (!mst_bus.cyc) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NREQ - 1);
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end

    assign vpa_o   = slv_bus.vpa;
    assign cyc_o   = slv_bus.cyc;
    assign stb_o   = slv_bus.stb;
    assign we_o    = slv_bus.we;
    assign sel_o   = slv_bus.sel;
    assign adr_o   = slv_bus.adr;
    assign dat_o   = slv_bus.dat;
    assign gnt_o   = gnt_q;
    assign m_dat_o = dat_i;

endmodule

// File: tb/tb_any1_bus_arbiter.sv
// tb/tb_any1_bus_arbiter.sv - directed bench with a cycle model and write scoreboard
module tb_any1_bus_arbiter;

    localparam int NREQ = 3;
    localparam int TMO  = 8;
    localparam int M_FREE = 0, M_BUS = 1, M_ERR = 2, M_DRAIN = 3;

    typedef struct {
        logic [31:0]  adr;
        logic [15:0]  sel;
        logic [127:0] dat;
    } wr_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]        m_vpa_i = '0, m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
    logic [NREQ-1:0][15:0]  m_sel_i = '0;
    logic [NREQ-1:0][31:0]  m_adr_i = '0;
    logic [NREQ-1:0][127:0] m_dat_i = '0;
    logic [NREQ-1:0]        m_ack_o, m_err_o, gnt_o;
    logic [127:0]           m_dat_o, dat_o;
    logic                   vpa_o, cyc_o, stb_o, we_o;
    logic [15:0]            sel_o;
    logic [31:0]            adr_o;
    logic                   ack_i = 1'b0;
    logic [127:0]           dat_i = '0;

    any1_bus_arbiter #(.NREQ(NREQ), .TMO(TMO), .TMOW(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_vpa_i(m_vpa_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .vpa_o(vpa_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .dat_i(dat_i), .gnt_o(gnt_o)
    );

    int n_checks = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: who owns the bus, what phase, how long the slave has stalled.
    int m_owner = -1, m_last = NREQ - 1, m_stall = 0, m_mode = M_FREE;

    always @(posedge clk) begin
        if (rst_i) begin
            m_owner = -1; m_last = NREQ - 1; m_stall = 0; m_mode = M_FREE;
        end else begin
            case (m_mode)
                M_FREE: begin
                    for (int k = 1; k <= NREQ; k++)
                        if (m_mode == M_FREE && m_cyc_i[(m_last + k) % NREQ]) begin
                            m_owner = (m_last + k) % NREQ;
                            m_mode  = M_BUS;
                        end
                    if (m_mode == M_BUS) begin
                        m_last = m_owner; m_stall = 0;
                    end
                end
                M_BUS: begin
                    if (!m_cyc_i[m_owner]) begin
                        m_mode = M_FREE; m_owner = -1; m_stall = 0;
                    end else if (m_stb_i[m_owner] && !ack_i) begin
                        m_stall++;
                        if (m_stall == TMO) begin m_mode = M_ERR; m_stall = 0; end
                    end else begin
                        m_stall = 0;
                    end
                end
                M_ERR: m_mode = M_DRAIN;
                default: if (!m_cyc_i[m_owner]) begin m_mode = M_FREE; m_owner = -1; end
            endcase
        end
    end

    wr_t wq [NREQ][$];

    always @(negedge clk) begin
        logic [NREQ-1:0] e_gnt, e_ack, e_err;
        logic [3:0]      e_ctl;
        logic [15:0]     e_sel;
        logic [31:0]     e_adr;
        logic [127:0]    e_dat;
        wr_t             w;
        if (chk_en) begin
            e_gnt = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
            e_ctl = '0; e_sel = '0; e_adr = '0; e_dat = '0; e_ack = '0; e_err = '0;
            if (m_mode == M_BUS) begin
                e_ctl = {m_vpa_i[m_owner], m_cyc_i[m_owner], m_stb_i[m_owner], m_we_i[m_owner]};
                e_sel = m_sel_i[m_owner];
                e_adr = m_adr_i[m_owner];
                e_dat = m_dat_i[m_owner];
                if (ack_i && m_stb_i[m_owner]) e_ack = e_gnt;
            end
            if (m_mode == M_ERR) e_err = e_gnt;
            check("gnt", gnt_o, e_gnt);
            check("ctl", {vpa_o, cyc_o, stb_o, we_o}, e_ctl);
            check("sel", sel_o, e_sel);
            check("adr", adr_o, e_adr);
            check("wdat", dat_o, e_dat);
            check("ack", m_ack_o, e_ack);
            check("err", m_err_o, e_err);
            check("rdat", m_dat_o, dat_i);
            if (m_mode == M_BUS && m_cyc_i[m_owner] && m_stb_i[m_owner] && m_we_i[m_owner] && ack_i) begin
                if (wq[m_owner].size() == 0) begin
                    check("sb_pending", wq[m_owner].size(), 1);
                end else begin
                    w = wq[m_owner].pop_front();
                    check("sb_adr", adr_o, w.adr);
                    check("sb_sel", sel_o, w.sel);
                    check("sb_dat", dat_o, w.dat);
                end
            end
        end
    end

    // Master agents and slave responder, all stepped from the stimulus thread.
    logic [31:0] base [NREQ];
    int nbeat [NREQ], beat [NREQ], hold [NREQ], rearm [NREQ], acks [NREQ];
    logic act [NREQ], wen [NREQ];
    logic slave_en = 1'b0, stray = 1'b0;
    int lat = 1, run = 0;
    logic [NREQ-1:0] s_ack, s_err, s_gnt, prev_gnt = '0;
    logic s_stb, s_cyc;
    logic [31:0] s_adr;
    int stb_cycles = 0, err_cycles = 0, zero_run = 0;
    logic [NREQ-1:0] err_vec = '0;
    int order[$], gaps[$], acks0_at_grant[$];

    function automatic wr_t beat_of(input int i, input int b);
        wr_t w;
        w.adr = base[i] + 32'(b * 16);
        w.sel = 16'hFFFF ^ (16'h1 << b);
        w.dat = {w.adr, ~w.adr, w.adr ^ 32'(i), 32'hC0DE_0000 + 32'(b)};
        return w;
    endfunction

    task automatic drive(input int i);
        wr_t w;
        w = beat_of(i, beat[i]);
        m_adr_i[i] = w.adr; m_sel_i[i] = w.sel; m_dat_i[i] = w.dat;
    endtask

    task automatic start(input int i, input logic [31:0] b, input int n, input logic w);
        base[i] = b; nbeat[i] = n; wen[i] = w; beat[i] = 0; hold[i] = 0; act[i] = 1'b1;
        m_cyc_i[i] = 1'b1; m_stb_i[i] = 1'b1; m_we_i[i] = w; m_vpa_i[i] = (i == 0);
        drive(i);
        if (w) for (int k = 0; k < n; k++) wq[i].push_back(beat_of(i, k));
    endtask

    task automatic drop(input int i);
        act[i] = 1'b0;
        m_cyc_i[i] = 1'b0; m_stb_i[i] = 1'b0; m_we_i[i] = 1'b0; m_vpa_i[i] = 1'b0;
    endtask

    task automatic abort_all();
        for (int i = 0; i < NREQ; i++) begin
            drop(i); rearm[i] = 0; hold[i] = 0; wq[i].delete();
        end
    endtask

    function automatic logic busy();
        logic b = 1'b0;
        for (int i = 0; i < NREQ; i++) if (act[i] || rearm[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic cycle();
        @(negedge clk);
        s_ack = m_ack_o; s_err = m_err_o; s_gnt = gnt_o; s_stb = stb_o; s_cyc = cyc_o; s_adr = adr_o;
        if (s_stb) stb_cycles++;
        if (s_err != 0) begin err_cycles++; err_vec = s_err; end
        for (int i = 0; i < NREQ; i++) if (s_ack[i]) acks[i]++;
        if (s_gnt != 0 && prev_gnt == 0) begin
            for (int i = 0; i < NREQ; i++) if (s_gnt[i]) order.push_back(i);
            gaps.push_back(zero_run);
            acks0_at_grant.push_back(acks[0]);
        end
        zero_run = (s_gnt == 0) ? zero_run + 1 : 0;
        prev_gnt = s_gnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (act[i]) begin
                if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) begin drop(i); wq[i].delete(); end
                end else if (s_err[i]) begin
                    hold[i] = 3;
                end else if (s_ack[i]) begin
                    beat[i]++;
                    if (beat[i] == nbeat[i]) drop(i); else drive(i);
                end
            end else if (rearm[i] > 0) begin
                rearm[i]--;
                start(i, base[i] + 32'h100, 1, wen[i]);
            end
        end
        if (stray) begin
            ack_i = 1'b1;
        end else if (slave_en) begin
            if (ack_i) begin ack_i = 1'b0; run = 0; end
            else if (s_stb) begin run++; if (run >= lat) ack_i = 1'b1; end
            else run = 0;
        end else begin
            ack_i = 1'b0;
        end
        dat_i = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        do begin cycle(); n++; end while ((busy() || s_gnt != 0) && n < budget);
        if (busy() || s_gnt != 0) begin
            n_checks++; n_err++;
            $display("FAIL wait_quiet: bus busy=%0d gnt=%0h after %0d cycles, required idle", busy(), s_gnt, budget);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NREQ; i++) acks[i] = 0;
        stb_cycles = 0; err_cycles = 0; err_vec = '0;
        order.delete(); gaps.delete(); acks0_at_grant.delete();
    endtask

    task automatic do_reset();
        rst_i = 1'b1; cycle(); cycle(); rst_i = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < NREQ; i++) begin
            base[i] = '0; nbeat[i] = 0; beat[i] = 0; hold[i] = 0; rearm[i] = 0; acks[i] = 0;
            act[i] = 1'b0; wen[i] = 1'b0;
        end
        cycle(); cycle();
        chk_en = 1'b1;
        cycle();
        check("rst_gnt", s_gnt, 3'b000);
        check("rst_cyc", s_cyc, 1'b0);
        rst_i = 1'b0;

        // Single master, one write, slave acks one clock after strobe
        lat = 1; slave_en = 1'b1;
        start(1, 32'h0000_0100, 1, 1'b1);
        cycle(); check("t1_req_cyc", s_cyc, 1'b0);
        cycle(); check("t1_cyc", s_cyc, 1'b1); check("t1_adr", s_adr, 32'h0000_0100);
        cycle(); check("t1_ack", s_ack, 3'b010);
        cycle(); check("t1_drop_cyc", s_cyc, 1'b0);
        cycle(); check("t1_idle_gnt", s_gnt, 3'b000);
        wait_quiet(50);

        // Three-way contention from reset, master 0 asks again after its turn
        do_reset(); clear_stats();
        rearm[0] = 1;
        start(0, 32'h0000_1000, 1, 1'b1);
        start(1, 32'h0000_2000, 1, 1'b0);
        start(2, 32'h0000_3000, 1, 1'b1);
        wait_quiet(100);
        check("t2_ngrants", order.size(), 4);
        if (order.size() == 4) begin
            check("t2_g0", order[0], 0); check("t2_g1", order[1], 1);
            check("t2_g2", order[2], 2); check("t2_g3", order[3], 0);
            check("t2_gap1", gaps[1], 1); check("t2_gap2", gaps[2], 1); check("t2_gap3", gaps[3], 1);
        end

        // Burst hold: master 0 keeps the bus for four beats while master 1 waits
        clear_stats();
        start(0, 32'hFF00_0000, 4, 1'b1);
        cycle();
        start(1, 32'h0000_0200, 1, 1'b1);
        wait_quiet(100);
        check("t3_ngrants", order.size(), 2);
        if (order.size() == 2) begin
            check("t3_first", order[0], 0); check("t3_second", order[1], 1);
            check("t3_acks_before_m1", acks0_at_grant[1], 4);
        end

        // Timeout: slave silent, error after TMO stalled strobes, then drain with a stray ack
        clear_stats(); slave_en = 1'b0;
        start(2, 32'h0000_0300, 1, 1'b0);
        n = 0;
        while (err_cycles == 0 && n < 40) begin cycle(); n++; end
        check("t4_err_seen", err_cycles, 1);
        stray = 1'b1; ack_i = 1'b1;
        cycle();
        check("t4_drain_cyc", s_cyc, 1'b0);
        check("t4_drain_gnt", s_gnt, 3'b100);
        cycle();
        stray = 1'b0; ack_i = 1'b0;
        wait_quiet(50);
        check("t4_stb_cycles", stb_cycles, 8);
        check("t4_err_cycles", err_cycles, 1);
        check("t4_err_vec", err_vec, 3'b100);
        check("t4_drain_acks", acks[2], 0);

        // Stray ack while idle
        clear_stats();
        stray = 1'b1; ack_i = 1'b1;
        cycle(); cycle(); cycle();
        stray = 1'b0; ack_i = 1'b0;
        cycle();
        check("t6_idle_acks", acks[0] + acks[1] + acks[2], 0);

        // Ack arriving on the last strobe before timeout wins
        clear_stats(); slave_en = 1'b1; lat = 7;
        start(2, 32'h0000_0310, 1, 1'b1);
        wait_quiet(60);
        check("t4b_err_cycles", err_cycles, 0);
        check("t4b_acks", acks[2], 1);
        check("t4b_stb_cycles", stb_cycles, 8);

        // Reset in the middle of a write burst
        lat = 1; clear_stats();
        start(0, 32'h0000_0400, 3, 1'b1);
        cycle(); cycle(); cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        abort_all(); clear_stats();
        start(1, 32'h0000_0500, 1, 1'b1);
        start(0, 32'h0000_0600, 1, 1'b1);
        cycle();
        check("t5_rst_cyc", s_cyc, 1'b0);
        check("t5_rst_gnt", s_gnt, 3'b000);
        check("t5_rst_ack", s_ack, 3'b000);
        cycle();
        check("t5_first_gnt", s_gnt, 3'b001);
        wait_quiet(60);
        check("t5_order_n", order.size(), 2);
        if (order.size() == 2) check("t5_second", order[1], 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
